fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Pointer and flag controller for the UART FIFO buffers, built as the stage that feeds the register file's write/read ports. It turns push/pop requests from the UART rx/tx datapath into the register file's `wr_en`, `w_addr` and `r_addr` controls. It also keeps full/empty flags, an occupancy count and overflow/underflow error pulses. Together with the register file it forms a circular FIFO of depth 2^W.

## Interface
- `W`, default 3: address width. FIFO depth is 2^W entries, and it matches the register file's `W`.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `wr` input 1: push request, sampled on the rising edge.
- `rd` input 1: pop request, sampled on the rising edge.
- `wr_en` output 1: write enable to the register file. Combinational: `wr & ~full`.
- `w_addr` output W: register file write address, equal to the registered write pointer.
- `r_addr` output W: register file read address, equal to the registered read pointer.
- `empty` output 1: registered; FIFO holds 0 entries.
- `full` output 1: registered; FIFO holds 2^W entries.
- `count` output W+1: registered occupancy, range 0..2^W.
- `overflow` output 1: registered one-cycle pulse; a push was rejected.
- `underflow` output 1: registered one-cycle pulse; a pop was rejected.

## Operation
**Reset values** (while `rst` = 0, applied immediately, independent of `clk`):
- `w_ptr` = 0, `r_ptr` = 0, `count` = 0
- `empty` = 1, `full` = 0, `overflow` = 0, `underflow` = 0

**Request acceptance** uses the flag values registered before the edge:
- `push_ok` = `wr & ~full`
- `pop_ok` = `rd & ~empty`

**Per-edge behaviour** (all pointer arithmetic is modulo 2^W; W-bit wrap from 2^W-1 to 0 is natural):
- **`push_ok` only:** `w_ptr` ← `w_ptr`+1, `count` ← `count`+1, `empty` ← 0, `full` ← (`w_ptr`+1 == `r_ptr`).
- **`pop_ok` only:** `r_ptr` ← `r_ptr`+1, `count` ← `count`-1, `full` ← 0, `empty` ← (`r_ptr`+1 == `w_ptr`).
- **`push_ok` and `pop_ok`:** both pointers advance. `count`, `full` and `empty` are unchanged.
- **Neither:** all state holds.

**Error pulses:**
- `overflow` ← `wr & full`, so a write to a full FIFO is dropped: `wr_en` = 0 and nothing changes.
- `underflow` ← `rd & empty`, so a read from an empty FIFO is ignored and `r_ptr` holds.

**Simultaneous requests at the boundaries:**
- `wr` & `rd` while full: only the pop is accepted. Result is `full` = 0, `count` = 2^W-1, and `overflow` pulses.
- `wr` & `rd` while empty: only the push is accepted. Result is `empty` = 0, `count` = 1, and `underflow` pulses.

**Invariants:**
- `full` and `empty` are never 1 together.
- `count` == 0 exactly when `empty`; `count` == 2^W exactly when `full`.
- `count` == (`w_ptr` - `r_ptr`) mod 2^W, except when full.

**Reset mid-operation:** all state returns to the reset values asynchronously. Register file contents are not cleared by this block. The first edge after `rst` deasserts is a normal edge.

## Timing
- `wr_en` is combinational from `wr` and the registered `full`. The register file captures `w_data` at the same edge that advances `w_ptr`.
- Push latency: the edge that accepts a push deasserts `empty` and updates `count`. The pushed word is readable through the register file's combinational read path in the following cycle.
- Pop: `r_addr` advances on the accepting edge. The consumer samples the read data before that edge, in the cycle `rd` is high (show-ahead FIFO).
- `overflow` and `underflow` are high for exactly the one cycle following the offending edge. Back-to-back rejected requests give consecutive pulses.
- Every output except `wr_en` is free of combinational paths from its inputs.

## Test plan
(All with W=3, depth 8.)
1. Reset and first push:
   - Stimulus: hold `rst`=0 for 2 cycles, then release and push 1 word.
   - Required: during reset `empty`=1, `full`=0, `count`=0, `w_addr`=`r_addr`=0. After the push, `empty`=0, `count`=1, `w_addr`=1, `r_addr`=0.
2. Fill and overflow:
   - Stimulus: 8 consecutive pushes, then a 9th with `wr`=1.
   - Required: after the 8th push `full`=1, `count`=8, `w_addr`=0. On the 9th, `wr_en`=0, one `overflow` pulse, and `w_addr`/`count` unchanged.
3. Drain and underflow:
   - Stimulus: from full, 8 pops, then a 9th.
   - Required: `r_addr` steps 0→7→0 and `empty`=1 after the 8th pop. The 9th gives one `underflow` pulse and no pointer change.
4. Simultaneous read and write, mid-range:
   - Stimulus: with `count`=3, hold `wr`=`rd`=1 for 10 cycles.
   - Required: `count` stays 3, both pointers advance 10 (mod 8, wrap exercised), no error pulses.
5. Simultaneous read and write at the boundaries:
   - Stimulus: `wr`=`rd`=1 once when full, and once when empty.
   - Required: when full, `count` 8→7, `full`=0, `overflow` pulses. When empty, `count` 0→1, `empty`=0, `underflow` pulses.
6. Asynchronous reset mid-operation:
   - Stimulus: with `count`=5, drive `rst`=0 between clock edges.
   - Required: outputs go to reset values immediately, without waiting for `clk`. After release, a push gives `w_addr`=1, `count`=1.

Source files
------------

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a circular FIFO of depth 2**W built around
// an external register file: issues wr_en/w_addr/r_addr and keeps full/empty/count.
module fifo_ctrl #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic         rd,
  output logic         wr_en,
  output logic [W-1:0] w_addr,
  output logic [W-1:0] r_addr,
  output logic         empty,
  output logic         full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  // Request semantics: wr/rd are sampled every rising edge. A push is accepted
  // when wr & ~full, a pop when rd & ~empty, both judged on the registered
  // flags before the edge. A rejected request is dropped and pulses
  // overflow/underflow for the following cycle; nothing else changes.

  logic [W-1:0] w_ptr_q, w_ptr_d;
  logic [W-1:0] r_ptr_q, r_ptr_d;
  logic [W:0]   count_q, count_d;
  logic         empty_q, empty_d;
  logic         full_q, full_d;
  logic         overflow_q, overflow_d;
  logic         underflow_q, underflow_d;

  logic         push_ok;
  logic         pop_ok;
  logic [W-1:0] w_ptr_inc;
  logic [W-1:0] r_ptr_inc;

  always_comb begin
    push_ok     = wr & ~full_q;
    pop_ok      = rd & ~empty_q;
    w_ptr_inc   = w_ptr_q + 1'b1;
    r_ptr_inc   = r_ptr_q + 1'b1;

    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    empty_d     = empty_q;
    full_d      = full_q;
    overflow_d  = wr & full_q;
    underflow_d = rd & empty_q;

    case ({push_ok, pop_ok})
      2'b10: begin
        w_ptr_d = w_ptr_inc;
        count_d = count_q + 1'b1;
        empty_d = 1'b0;
        full_d  = (w_ptr_inc == r_ptr_q);
      end
      2'b01: begin
        r_ptr_d = r_ptr_inc;
        count_d = count_q - 1'b1;
        full_d  = 1'b0;
        empty_d = (r_ptr_inc == w_ptr_q);
      end
      // Simultaneous accepted push and pop leaves occupancy and flags intact.
      2'b11: begin
        w_ptr_d = w_ptr_inc;
        r_ptr_d = r_ptr_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_en     = wr & ~full_q;
  assign w_addr    = w_ptr_q;
  assign r_addr    = r_ptr_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl (W=3, depth 8): reset, fill/overflow,
// drain/underflow, simultaneous requests and asynchronous reset.
module tb_fifo_ctrl;

  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic         wr;
  logic         rd;
  logic         wr_en;
  logic [W-1:0] w_addr;
  logic [W-1:0] r_addr;
  logic         empty;
  logic         full;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;

  int n_total = 0;
  int n_pass  = 0;

  fifo_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr),
    .rd        (rd),
    .wr_en     (wr_en),
    .w_addr    (w_addr),
    .r_addr    (r_addr),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      wr = 1'b1; rd = 1'b0;
      tick();
    end
    wr = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      wr = 1'b0; rd = 1'b1;
      tick();
    end
    rd = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    wr  = 1'b0;
    rd  = 1'b0;

    // 1. reset and first push
    tick();
    tick();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_waddr", w_addr, 0);
    check("rst_raddr", r_addr, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    rst = 1'b1;
    wr  = 1'b1;
    #1;
    check("t1_wr_en", wr_en, 1);
    tick();
    wr = 1'b0;
    check("t1_empty", empty, 0);
    check("t1_count", count, 1);
    check("t1_waddr", w_addr, 1);
    check("t1_raddr", r_addr, 0);

    // 2. fill (8 pushes total) and overflow
    push_n(7);
    check("t2_full", full, 1);
    check("t2_empty", empty, 0);
    check("t2_count", count, 8);
    check("t2_waddr", w_addr, 0);
    wr = 1'b1;
    #1;
    check("t2_wr_en_blocked", wr_en, 0);
    tick();
    wr = 1'b0;
    check("t2_ovf_pulse", overflow, 1);
    check("t2_waddr_hold", w_addr, 0);
    check("t2_count_hold", count, 8);
    check("t2_full_hold", full, 1);
    tick();
    check("t2_ovf_clear", overflow, 0);

    // 3. drain and underflow
    for (int i = 0; i < 8; i++) begin
      check("t3_raddr_step", r_addr, i);
      rd = 1'b1;
      tick();
    end
    rd = 1'b0;
    check("t3_raddr_wrap", r_addr, 0);
    check("t3_empty", empty, 1);
    check("t3_full", full, 0);
    check("t3_count", count, 0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("t3_unf_pulse", underflow, 1);
    check("t3_raddr_hold", r_addr, 0);
    check("t3_count_hold", count, 0);
    tick();
    check("t3_unf_clear", underflow, 0);

    // 4. simultaneous read/write mid-range
    push_n(3);
    check("t4_count_pre", count, 3);
    for (int i = 0; i < 10; i++) begin
      wr = 1'b1; rd = 1'b1;
      tick();
      check("t4_count", count, 3);
      check("t4_ovf", overflow, 0);
      check("t4_unf", underflow, 0);
    end
    wr = 1'b0; rd = 1'b0;
    check("t4_waddr", w_addr, 5);
    check("t4_raddr", r_addr, 2);

    // 5. simultaneous read/write at full and at empty
    push_n(5);
    check("t5_full_pre", full, 1);
    check("t5_waddr_pre", w_addr, 2);
    wr = 1'b1; rd = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0;
    check("t5f_count", count, 7);
    check("t5f_full", full, 0);
    check("t5f_ovf", overflow, 1);
    check("t5f_unf", underflow, 0);
    check("t5f_waddr", w_addr, 2);
    check("t5f_raddr", r_addr, 3);
    pop_n(7);
    check("t5_empty_pre", empty, 1);
    check("t5_raddr_pre", r_addr, 2);
    wr = 1'b1; rd = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0;
    check("t5e_count", count, 1);
    check("t5e_empty", empty, 0);
    check("t5e_unf", underflow, 1);
    check("t5e_ovf", overflow, 0);
    check("t5e_waddr", w_addr, 3);
    check("t5e_raddr", r_addr, 2);

    // 6. asynchronous reset mid-operation
    push_n(4);
    check("t6_count_pre", count, 5);
    check("t6_waddr_pre", w_addr, 7);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_count", count, 0);
    check("t6_async_empty", empty, 1);
    check("t6_async_full", full, 0);
    check("t6_async_waddr", w_addr, 0);
    check("t6_async_raddr", r_addr, 0);
    tick();
    #2;
    rst = 1'b1;
    wr  = 1'b1;
    tick();
    wr = 1'b0;
    check("t6_post_waddr", w_addr, 1);
    check("t6_post_count", count, 1);
    check("t6_post_empty", empty, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
